// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with per-channel tick pulses
// Optional macro CLKDIV_SYNC_EN adds sync_req, which phase-aligns every channel.
module clk_div_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 24,
  parameter int DEF_DIV  = 1250000
) (
  input  logic                      sysclk,
  input  logic                      rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic                      sync_req,
`endif
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*CNT_W-1:0] div_in,
  input  logic [CHANNELS-1:0]       div_wr,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       div_pend
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] wr_val;
    logic             co;
    logic             tk;
    logic             pd;
    logic             wrap;
    logic             load;

    assign wr_val = div_in[k*CNT_W +: CNT_W];
    // Wrap is by compare against active, so the full counter range never overflows.
    assign wrap   = en[k] && (cnt == active);
    assign load   = div_wr[k] || pd;

    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        co     <= 1'b0;
        tk     <= 1'b0;
        pd     <= 1'b0;
        active <= RST_DIV;
        shadow <= RST_DIV;
      end
`ifdef CLKDIV_SYNC_EN
      else if (sync_req) begin
        cnt    <= '0;
        co     <= 1'b0;
        tk     <= 1'b0;
        pd     <= 1'b0;
        active <= div_wr[k] ? wr_val : shadow;
        if (div_wr[k]) begin
          shadow <= wr_val;
        end
      end
`endif
      else begin
        if (div_wr[k]) begin
          shadow <= wr_val;
          pd     <= 1'b1;
        end
        if (wrap) begin
          cnt <= '0;
          co  <= ~co;
          tk  <= 1'b1;
          // A write landing on the wrap cycle bypasses the shadow and applies immediately.
          if (load) begin
            active <= div_wr[k] ? wr_val : shadow;
            pd     <= 1'b0;
          end
        end else begin
          tk <= 1'b0;
          if (en[k]) begin
            cnt <= cnt + ONE;
          end
        end
      end
    end

    assign clk_out[k]  = co;
    assign tick[k]     = tk;
    assign div_pend[k] = pd;
  end

endmodule
